// File: rtl/mux2to1_pkg.sv
// Shared defaults and saturating-increment helper for the mux2to1 slice.
// Statistics logic is built only when MUX2TO1_STATS_EN is defined.
package mux2to1_pkg;

    localparam int WIDTH_DEF = 1;
    localparam int CNT_W_DEF = 16;
    localparam int MAX_CNT_W = 32;

    // Increment v, holding at 2^w-1; w may be at most MAX_CNT_W.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] v,
        input int                   w
    );
        logic [MAX_CNT_W:0] lim;
        lim = ((MAX_CNT_W+1)'(1) << w) - (MAX_CNT_W+1)'(1);
        if ({1'b0, v} >= lim)
            return v;
        return v + MAX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/mux2to1_sat_cnt.sv
// Saturating event counter with synchronous active-high reset.
// Reset wins over increment, including at saturation.
module mux2to1_sat_cnt
    import mux2to1_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (inc)
            cnt <= CNT_W'(sat_inc(MAX_CNT_W'(cnt), CNT_W));
    end

endmodule

// File: rtl/mux2to1.sv
// 2:1 mux with registered copy; optional select statistics.
// Define MUX2TO1_STATS_EN to build s_q and the two counters.
module mux2to1
    import mux2to1_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [CNT_W-1:0] sel_toggles,
    output logic [CNT_W-1:0] b_cycles
);

    // Pure conditional operator keeps X-select merging of a/b.
    assign out = s ? b : a;

    always_ff @(posedge clock) begin
        if (reset)
            out_q <= '0;
        else
            out_q <= out;
    end

`ifdef MUX2TO1_STATS_EN
    logic s_q;
    logic armed_q;
    logic toggle;

    // armed_q masks the first post-reset cycle from toggle counting.
    always_ff @(posedge clock) begin
        s_q <= s;
        if (reset)
            armed_q <= 1'b0;
        else
            armed_q <= 1'b1;
    end

    assign toggle = armed_q && (s != s_q);

    mux2to1_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_tog_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (toggle),
        .cnt   (sel_toggles)
    );

    mux2to1_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_b_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (s),
        .cnt   (b_cycles)
    );
`else
    assign sel_toggles = '0;
    assign b_cycles    = '0;
`endif

endmodule

// File: tb/tb_mux2to1.sv
// Scoreboard bench for mux2to1: a 1-bit/16-bit-counter and an
// 8-bit/4-bit-counter instance share clock, reset and select.
module tb_mux2to1;

`ifdef MUX2TO1_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int K_OUT0  = 0;
    localparam int K_OUTQ0 = 1;
    localparam int K_TOG0  = 2;
    localparam int K_BC0   = 3;
    localparam int K_OUT1  = 4;
    localparam int K_OUTQ1 = 5;
    localparam int K_TOG1  = 6;
    localparam int K_BC1   = 7;

    logic        clock = 1'b0;
    logic        reset;
    logic        s;
    logic [0:0]  a0, b0, out0, outq0;
    logic [7:0]  a1, b1, out1, outq1;
    logic [15:0] tog0, bc0;
    logic [3:0]  tog1, bc1;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    event  chk_ev;
    int    n_checks = 0;
    int    n_pass   = 0;

    always #50 clock = ~clock;

    mux2to1 #(.WIDTH(1), .CNT_W(16)) u_dut0 (
        .clock       (clock),
        .reset       (reset),
        .a           (a0),
        .b           (b0),
        .s           (s),
        .out         (out0),
        .out_q       (outq0),
        .sel_toggles (tog0),
        .b_cycles    (bc0)
    );

    mux2to1 #(.WIDTH(8), .CNT_W(4)) u_dut1 (
        .clock       (clock),
        .reset       (reset),
        .a           (a1),
        .b           (b1),
        .s           (s),
        .out         (out1),
        .out_q       (outq1),
        .sel_toggles (tog1),
        .b_cycles    (bc1)
    );

    function automatic logic [31:0] probe(input int k);
        case (k)
            K_OUT0:  return 32'(out0);
            K_OUTQ0: return 32'(outq0);
            K_TOG0:  return 32'(tog0);
            K_BC0:   return 32'(bc0);
            K_OUT1:  return 32'(out1);
            K_OUTQ1: return 32'(outq1);
            K_TOG1:  return 32'(tog1);
            default: return 32'(bc1);
        endcase
    endfunction

    // Monitor: drains every queued expectation against the live DUT.
    initial begin
        item_t it;
        logic [31:0] act;
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                it  = q.pop_front();
                act = probe(it.kind);
                n_checks++;
                if (act === it.exp)
                    n_pass++;
                else
                    $display("FAIL %s: got %0h expected %0h at %0t",
                             it.name, act, it.exp, $time);
            end
        end
    end

    task automatic chk(input int k, input logic [31:0] e,
                       input string nm);
        item_t it;
        it.kind = k;
        it.exp  = e;
        it.name = nm;
        q.push_back(it);
        -> chk_ev;
    endtask

    function automatic logic [7:0] sel8(input logic sv,
                                        input logic [7:0] av,
                                        input logic [7:0] bv);
        if (sv == 1'b1)
            return bv;
        return av;
    endfunction

    // Drive at the falling edge, then check the combinational outputs.
    task automatic drive(input logic rv, input logic sv,
                         input logic [0:0] av0, input logic [0:0] bv0,
                         input logic [7:0] av1, input logic [7:0] bv1);
        @(negedge clock);
        reset = rv;
        s     = sv;
        a0    = av0;
        b0    = bv0;
        a1    = av1;
        b1    = bv1;
        #1;
        chk(K_OUT0, 32'(sel8(s, 8'(a0), 8'(b0))), "out0");
        chk(K_OUT1, 32'(sel8(s, a1, b1)), "out1");
    endtask

    // Clock one edge and check out_q picked up the pre-edge mux value.
    task automatic edge_chk();
        logic [7:0] e0, e1;
        e0 = reset ? 8'h00 : sel8(s, 8'(a0), 8'(b0));
        e1 = reset ? 8'h00 : sel8(s, a1, b1);
        @(posedge clock);
        #1;
        chk(K_OUTQ0, 32'(e0), "out_q0");
        chk(K_OUTQ1, 32'(e1), "out_q1");
    endtask

    task automatic cnt_chk(input int t0, input int c0,
                           input int t1, input int c1,
                           input string nm);
        chk(K_TOG0, STATS ? 32'(t0) : 32'd0, {nm, "_tog0"});
        chk(K_BC0,  STATS ? 32'(c0) : 32'd0, {nm, "_bc0"});
        chk(K_TOG1, STATS ? 32'(t1) : 32'd0, {nm, "_tog1"});
        chk(K_BC1,  STATS ? 32'(c1) : 32'd0, {nm, "_bc1"});
    endtask

    initial begin
        logic [19:0] pat;
        logic [2:0]  v;
        reset = 1'b1;
        s     = 1'b0;
        a0    = '0;
        b0    = '0;
        a1    = '0;
        b1    = '0;

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        edge_chk();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 8'h22);
        edge_chk();
        cnt_chk(0, 0, 0, 0, "rst");

        // Exhaustive 1-bit sweep, reset asserted, no settling time
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            v  = 3'(i);
            a0 = v[2];
            b0 = v[1];
            s  = v[0];
            a1 = 8'hA5;
            b1 = 8'h3C;
            #1;
            chk(K_OUT0, 32'(v[0] ? v[1] : v[2]), "sweep_out0");
            chk(K_OUT1, v[0] ? 32'h3C : 32'hA5, "sweep_out1");
            #1;
        end

        // Last reset edge samples s=0; then 5 toggles, 9 ones in 20
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        edge_chk();
        pat = 20'b1111_0000_0011_0001_1100;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, pat[i], 1'(i), 1'(~i), 8'(i * 7), 8'(i * 13));
            edge_chk();
        end
        cnt_chk(5, 9, 5, 9, "run20");

        // Hold s=1: 4-bit b counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 8'hF0, 8'h0F);
            edge_chk();
        end
        cnt_chk(5, 29, 5, 15, "hold1");

        // Alternate s each cycle: 4-bit toggle counter saturates
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'(i), 1'b0, 1'b1, 8'h55, 8'hAA);
            edge_chk();
        end
        cnt_chk(25, 39, 15, 15, "alt");

        // Reset mid-count with s toggling, then release with s changed
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
        edge_chk();
        cnt_chk(0, 0, 0, 0, "midrst");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
        edge_chk();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
        edge_chk();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34);
        edge_chk();
        cnt_chk(0, 1, 0, 1, "rel1");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h34);
        edge_chk();
        cnt_chk(1, 1, 1, 1, "rel2");

        // Random data every cycle, s inverted every 100 cycles
        s = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, (i % 100 == 0) ? ~s : s,
                  1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom));
            edge_chk();
        end

        #10;
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
